vsim_send_fifo: RTL and testbench
=================================

// Module: vsim_send_fifo
// PURPOSE
//  Simulation-only host-bound message sender: accepts PipeInLast beats of arbitrary
//  width into a DEPTH-entry FIFO and drains them to the C host one 32-bit word per
//  cycle via DPI, honouring host backpressure. Multi-channel capable via CHAN id.
//  Sits at the device-to-host edge of the verilator/vsim harness.
// PARAMETERS
//  width  32  beat data width; multiple of 32; WORDS = width/32
//  DEPTH  4   FIFO entries (power of 2, >=2); entry = {last, v[width-1:0]}
//  CHAN   0   channel id passed to every DPI call
// PORTS
//  CLK           in   1                    clock, all state on posedge
//  nRST          in   1                    asynchronous reset, active low
//  enq__ENA      in   1                    beat valid
//  enq$v         in   width                beat data
//  enq$last      in   1                    final beat of message
//  enq__RDY      out  1                    FIFO can accept a beat
//  fifo_count    out  $clog2(DEPTH+1)      entries held (excl. beat being drained)
//  busy          out  1                    drain FSM in SEND
//  overflow_err  out  1                    sticky: ENA seen while RDY low
//  sent_words    out  32                   words delivered to host, wraps 2^32
// BEHAVIOUR
//  DPI: int dpi_msgSend_ready(int chan); void dpi_msgSend_enq(int chan,int data,int last).
//  Reset (nRST low, async): count=0, ptrs=0, state=IDLE, idx=0, overflow_err=0,
//   sent_words=0, enq__RDY=0; no DPI calls while nRST low; partial message abandoned.
//  enq__RDY = nRST && (count != DEPTH); from registered count, no same-cycle bypass
//   (full FIFO popping this cycle still shows RDY=0).
//  Accept: ENA && RDY at posedge writes entry at wptr, wptr++ (mod DEPTH).
//  ENA && !RDY: beat dropped, overflow_err<=1 until reset.
//  FSM IDLE: if count!=0, load head into hold reg, pop (rptr++), idx=0 -> SEND.
//   Latency: beat accepted at edge N -> first DPI word earliest at edge N+2.
//  FSM SEND, per posedge: r = dpi_msgSend_ready(CHAN) sampled once;
//   r==0: hold (state, idx unchanged, no enq call).
//   r!=0: dpi_msgSend_enq(CHAN, hold[idx*32+:32], hold.last && idx==WORDS-1);
//    sent_words++; if idx<WORDS-1 idx++; else if count!=0 reload next head, pop,
//    idx=0, stay SEND (back-to-back, no bubble); else -> IDLE.
//  Word order: least-significant 32 bits first; last flag only on final word.
//  Simultaneous accept and pop: count unchanged; pointers both advance.
//  width==32: every accepted beat costs exactly one ready cycle.
//  `ifdef YOSYS: DPI body omitted; enq__RDY=1, other outputs 0.
// TESTING
//  1 width=32: enq 0xA5A5_0001 last=1, host ready always -> one call (0,0xA5A50001,1)
//    two edges after accept; sent_words=1; fifo_count back to 0.
//  2 width=96: enq v=0x3_00000002_00000001 last=1 -> calls data 1,2,3 on consecutive
//    cycles, last=0,0,1; busy high 3 cycles.
//  3 DEPTH=4, host ready=0: enq 6 beats back-to-back -> 5 accepted (4 FIFO + 1 hold),
//    RDY low after, overflow_err=1, fifo_count=4; release ready -> 5 messages in order.
//  4 host ready toggles 1,0,1,0 during width=64 beat -> word1 delayed one cycle, no
//    duplicate or lost words, sent_words=2.
//  5 drop nRST mid-message (after word 0 of 3) -> outputs reset immediately, no further
//    calls; after release, new beat 0x7 drains cleanly from word 0.
//  6 CHAN=3, two channels instanced -> each call carries own chan id, streams independent.

Source files
------------

// File: rtl/vsim_send_fifo_if.sv
// Beat intake and host word-delivery bundle for vsim_send_fifo.
// The host side stands in for the msgSend ready/enq calls, sampled at posedge.
interface vsim_send_fifo_if #(
  parameter int width = 32
);
  logic             enq__ENA;
  logic [width-1:0] enq_v;
  logic             enq_last;
  logic             enq__RDY;
  logic             msg_ready;
  logic             msg_enq;
  logic [31:0]      msg_chan;
  logic [31:0]      msg_data;
  logic             msg_last;

  modport slave (
    input  enq__ENA,
    input  enq_v,
    input  enq_last,
    input  msg_ready,
    output enq__RDY,
    output msg_enq,
    output msg_chan,
    output msg_data,
    output msg_last
  );

  modport master (
    output enq__ENA,
    output enq_v,
    output enq_last,
    output msg_ready,
    input  enq__RDY,
    input  msg_enq,
    input  msg_chan,
    input  msg_data,
    input  msg_last
  );
endinterface

// File: rtl/vsim_send_fifo.sv
// Host-bound message sender: DEPTH-entry beat FIFO drained to the host
// one 32-bit word per cycle, least-significant word first.
module vsim_send_fifo #(
  parameter int width = 32,
  parameter int DEPTH = 4,
  parameter int CHAN  = 0
) (
  input  logic                       CLK,
  input  logic                       nRST,
  vsim_send_fifo_if.slave            io,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       busy,
  output logic                       overflow_err,
  output logic [31:0]                sent_words
);
  localparam int WORDS = width / 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef struct packed {
    logic             last;
    logic [width-1:0] v;
  } entry_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  entry_t              mem [DEPTH];
  entry_t              hold;
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [CW-1:0]       count;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_n;
  state_t              state;
  state_t              state_n;
  logic                rdy;
  logic                acc;
  logic                drop;
  logic                pop;
  logic                call;
  logic                last_word;
  logic [(1<<IW)-1:0][31:0] hv;

  assign rdy       = (count != CW'(DEPTH));
  assign acc       = io.enq__ENA && rdy;
  assign drop      = io.enq__ENA && !rdy;
  assign last_word = (idx == IW'(WORDS - 1));

  always_comb begin
    hv = '0;
    for (int i = 0; i < WORDS; i++) begin
      hv[i] = hold.v[i*32 +: 32];
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    pop     = 1'b0;
    call    = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          idx_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (io.msg_ready) begin
          call = 1'b1;
          if (!last_word) begin
            idx_n = idx + IW'(1);
          end else if (count != '0) begin
            pop   = 1'b1;
            idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      hold         <= '0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      idx          <= '0;
      state        <= IDLE;
      overflow_err <= 1'b0;
      sent_words   <= '0;
    end else begin
      if (acc) begin
        mem[wptr] <= '{last: io.enq_last, v: io.enq_v};
        wptr      <= wptr + AW'(1);
      end
      if (drop) begin
        overflow_err <= 1'b1;
      end
      if (pop) begin
        hold <= mem[rptr];
        rptr <= rptr + AW'(1);
      end
      if (call) begin
        sent_words <= sent_words + 32'd1;
      end
      count <= count + CW'(acc) - CW'(pop);
      idx   <= idx_n;
      state <= state_n;
    end
  end

`ifdef YOSYS
  assign io.enq__RDY = 1'b1;
  assign io.msg_enq  = 1'b0;
  assign io.msg_chan = '0;
  assign io.msg_data = '0;
  assign io.msg_last = 1'b0;
  assign fifo_count  = '0;
  assign busy        = 1'b0;
`else
  assign io.enq__RDY = nRST && rdy;
  assign io.msg_enq  = nRST && call;
  assign io.msg_chan = 32'(CHAN);
  assign io.msg_data = hv[idx];
  assign io.msg_last = hold.last && last_word;
  assign fifo_count  = count;
  assign busy        = (state == SEND);
`endif
endmodule

// File: tb/tb_vsim_send_fifo.sv
// Scoreboard bench for vsim_send_fifo: expected host words queued per
// instance, popped and compared by a negedge monitor.
module tb_vsim_send_fifo;
  logic CLK = 1'b0;
  logic nRST;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  vsim_send_fifo_if #(.width(32)) i0 ();
  vsim_send_fifo_if #(.width(96)) i1 ();
  vsim_send_fifo_if #(.width(64)) i2 ();
  vsim_send_fifo_if #(.width(32)) i3 ();

  logic [2:0]  c0, c1, c2, c3;
  logic        b0, b1, b2, b3;
  logic        o0, o1, o2, o3;
  logic [31:0] s0, s1, s2, s3;

  vsim_send_fifo #(.width(32), .DEPTH(4), .CHAN(0)) d0 (
    .CLK(CLK), .nRST(nRST), .io(i0.slave), .fifo_count(c0),
    .busy(b0), .overflow_err(o0), .sent_words(s0));
  vsim_send_fifo #(.width(96), .DEPTH(4), .CHAN(0)) d1 (
    .CLK(CLK), .nRST(nRST), .io(i1.slave), .fifo_count(c1),
    .busy(b1), .overflow_err(o1), .sent_words(s1));
  vsim_send_fifo #(.width(64), .DEPTH(4), .CHAN(0)) d2 (
    .CLK(CLK), .nRST(nRST), .io(i2.slave), .fifo_count(c2),
    .busy(b2), .overflow_err(o2), .sent_words(s2));
  vsim_send_fifo #(.width(32), .DEPTH(4), .CHAN(3)) d3 (
    .CLK(CLK), .nRST(nRST), .io(i3.slave), .fifo_count(c3),
    .busy(b3), .overflow_err(o3), .sent_words(s3));

  logic [64:0] q0[$], q1[$], q2[$], q3[$];

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic push(input int k, input logic [31:0] ch,
                      input logic [31:0] d, input logic l);
    case (k)
      0: q0.push_back({ch, d, l});
      1: q1.push_back({ch, d, l});
      2: q2.push_back({ch, d, l});
      default: q3.push_back({ch, d, l});
    endcase
  endtask

  task automatic mon(input int k, input logic [64:0] act);
    logic [64:0] e;
    bit have;
    have = 0;
    e = '0;
    if (qsize(k) > 0) begin
      have = 1;
      case (k)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        default: e = q3.pop_front();
      endcase
    end
    tests++;
    if (!have) begin
      fails++;
      $display("FAIL unexpected_call dut%0d: got %0h expected none", k, act);
    end else if (act !== e) begin
      fails++;
      $display("FAIL call dut%0d: got %0h expected %0h", k, act, e);
    end
  endtask

  always @(negedge CLK) begin
    if (i0.msg_enq) mon(0, {i0.msg_chan, i0.msg_data, i0.msg_last});
    if (i1.msg_enq) mon(1, {i1.msg_chan, i1.msg_data, i1.msg_last});
    if (i2.msg_enq) mon(2, {i2.msg_chan, i2.msg_data, i2.msg_last});
    if (i3.msg_enq) mon(3, {i3.msg_chan, i3.msg_data, i3.msg_last});
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int k, input int budget);
    int n;
    n = 0;
    while (qsize(k) != 0 && n < budget) begin
      step();
      n++;
    end
    step();
    chk($sformatf("drain_dut%0d", k), 96'(qsize(k)), 96'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0;
    i0.enq__ENA = 0; i0.enq_v = '0; i0.enq_last = 0; i0.msg_ready = 1;
    i1.enq__ENA = 0; i1.enq_v = '0; i1.enq_last = 0; i1.msg_ready = 1;
    i2.enq__ENA = 0; i2.enq_v = '0; i2.enq_last = 0; i2.msg_ready = 1;
    i3.enq__ENA = 0; i3.enq_v = '0; i3.enq_last = 0; i3.msg_ready = 1;
    step();
    step();
    chk("rst_rdy", 96'(i0.enq__RDY), 96'd0);
    chk("rst_count", 96'(c0), 96'd0);
    chk("rst_busy", 96'(b0), 96'd0);
    chk("rst_ovf", 96'(o0), 96'd0);
    chk("rst_sent", 96'(s0), 96'd0);
    nRST = 1'b1;
    #1;
    chk("rdy_after_rst", 96'(i0.enq__RDY), 96'd1);
    step();

    // single 32-bit beat, two-edge latency
    i0.enq__ENA = 1; i0.enq_v = 32'hA5A5_0001; i0.enq_last = 1;
    push(0, 0, 32'hA5A5_0001, 1);
    step();
    i0.enq__ENA = 0;
    chk("t1_count_acc", 96'(c0), 96'd1);
    chk("t1_no_call_yet", 96'(i0.msg_enq), 96'd0);
    step();
    chk("t1_call_pending", 96'(i0.msg_enq), 96'd1);
    chk("t1_busy", 96'(b0), 96'd1);
    chk("t1_count_pop", 96'(c0), 96'd0);
    step();
    chk("t1_sent", 96'(s0), 96'd1);
    chk("t1_idle", 96'(b0), 96'd0);
    chk("t1_count_end", 96'(c0), 96'd0);

    // 96-bit beat, three words LSW first
    i1.enq__ENA = 1; i1.enq_v = 96'h3_00000002_00000001; i1.enq_last = 1;
    push(1, 0, 1, 0); push(1, 0, 2, 0); push(1, 0, 3, 1);
    step();
    i1.enq__ENA = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t2_busy%0d", i), 96'(b1), 96'd1);
    end
    step();
    chk("t2_busy_end", 96'(b1), 96'd0);
    chk("t2_sent", 96'(s1), 96'd3);

    // backpressure fill, overflow, ordered drain
    i0.msg_ready = 0;
    for (int i = 0; i < 6; i++) begin
      i0.enq__ENA = 1; i0.enq_v = 32'h100 + 32'(i); i0.enq_last = 1;
      if (i < 5) push(0, 0, 32'h100 + 32'(i), 1);
      step();
    end
    i0.enq__ENA = 0;
    chk("t3_ovf", 96'(o0), 96'd1);
    chk("t3_count", 96'(c0), 96'd4);
    chk("t3_rdy_low", 96'(i0.enq__RDY), 96'd0);
    i0.msg_ready = 1;
    drain(0, 20);
    chk("t3_sent", 96'(s0), 96'd6);
    chk("t3_ovf_sticky", 96'(o0), 96'd1);
    chk("t3_rdy_back", 96'(i0.enq__RDY), 96'd1);

    // toggling host ready on a 64-bit beat
    i2.enq__ENA = 1; i2.enq_v = 64'h00000BBB_00000AAA; i2.enq_last = 1;
    push(2, 0, 32'hAAA, 0); push(2, 0, 32'hBBB, 1);
    step();
    i2.enq__ENA = 0;
    step();
    i2.msg_ready = 1;
    step();
    i2.msg_ready = 0;
    step();
    chk("t4_held_sent", 96'(s2), 96'd1);
    chk("t4_held_busy", 96'(b2), 96'd1);
    i2.msg_ready = 1;
    step();
    i2.msg_ready = 0;
    step();
    chk("t4_sent", 96'(s2), 96'd2);
    chk("t4_idle", 96'(b2), 96'd0);
    chk("t4_q_empty", 96'(qsize(2)), 96'd0);
    i2.msg_ready = 1;

    // reset mid-message, then clean restart
    i1.enq__ENA = 1; i1.enq_v = 96'h0000000C_0000000B_0000000A;
    i1.enq_last = 1;
    push(1, 0, 32'hA, 0);
    step();
    i1.enq__ENA = 0;
    step();
    step();
    nRST = 1'b0;
    #1;
    chk("t5_busy", 96'(b1), 96'd0);
    chk("t5_sent", 96'(s1), 96'd0);
    chk("t5_rdy", 96'(i1.enq__RDY), 96'd0);
    chk("t5_enq", 96'(i1.msg_enq), 96'd0);
    step();
    step();
    nRST = 1'b1;
    step();
    i1.enq__ENA = 1; i1.enq_v = 96'h7; i1.enq_last = 1;
    push(1, 0, 7, 0); push(1, 0, 0, 0); push(1, 0, 0, 1);
    step();
    i1.enq__ENA = 0;
    drain(1, 20);
    chk("t5_sent_after", 96'(s1), 96'd3);

    // two channels side by side
    for (int i = 0; i < 2; i++) begin
      i0.enq__ENA = 1; i0.enq_v = 32'h600 + 32'(i); i0.enq_last = 1;
      i3.enq__ENA = 1; i3.enq_v = 32'h300 + 32'(i); i3.enq_last = 1'(i);
      push(0, 0, 32'h600 + 32'(i), 1);
      push(3, 3, 32'h300 + 32'(i), 1'(i));
      step();
    end
    i0.enq__ENA = 0;
    i3.enq__ENA = 0;
    drain(0, 20);
    drain(3, 20);
    chk("t6_sent0", 96'(s0), 96'd2);
    chk("t6_sent3", 96'(s3), 96'd2);
    chk("t6_ovf3", 96'(o3), 96'd0);

    step();
    chk("end_q", 96'(qsize(0) + qsize(1) + qsize(2) + qsize(3)), 96'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
